// File: rtl/counter_ctrl_pkg.sv
// counter_ctrl_pkg: state encodings and default sizes shared by the counter sequencer
package counter_ctrl_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HOLD = 2'd2} state_t;
  localparam int WIDTH_D = 4;
  localparam int PW_D = 8;
endpackage

// File: rtl/counter_ctrl_if.sv
// counter_ctrl_if: control/status bundle between test logic and the counter sequencer
interface counter_ctrl_if import counter_ctrl_pkg::*; #(parameter int WIDTH = WIDTH_D, parameter int PW = PW_D);
  logic start, stop, pause, mode;
  logic [WIDTH-1:0] tc, q;
  logic busy, done;
  logic [PW-1:0] periods;
  modport master(output start, stop, pause, mode, tc, input q, busy, done, periods);
  modport slave(input start, stop, pause, mode, tc, output q, busy, done, periods);
endinterface

// File: rtl/ctrl_counter.sv
// ctrl_counter: clearable, enabled up-counter with terminal compare
module ctrl_counter import counter_ctrl_pkg::*; #(parameter int WIDTH = WIDTH_D) (
  input  logic             ck,
  input  logic             res,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] tc_r,
  output logic [WIDTH-1:0] q,
  output logic             term
);
  always_ff @(posedge ck or negedge res)
    if (!res) q <= '0;
    else if (clr) q <= '0;
    else if (en) q <= q + 1'b1;
  assign term = q == tc_r;
endmodule

// File: rtl/counter_ctrl.sv
// counter_ctrl: run/stop sequencer with one-shot/auto-reload, pause, abort and period tally
module counter_ctrl import counter_ctrl_pkg::*; #(parameter int WIDTH = WIDTH_D, parameter int PW = PW_D) (
  input logic           ck,
  input logic           res,
  counter_ctrl_if.slave bus
);
  state_t state, state_n;
  logic [WIDTH-1:0] tc_r, q;
  logic [PW-1:0] periods;
  logic mode_r, clr, en, load, done_n, tally, term, done;
  ctrl_counter #(.WIDTH(WIDTH)) u_cnt (.ck(ck), .res(res), .clr(clr), .en(en), .tc_r(tc_r), .q(q), .term(term));
  always_comb begin
    state_n = state;
    clr = 1'b0;
    en = 1'b0;
    load = 1'b0;
    done_n = 1'b0;
    tally = 1'b0;
    if (bus.stop) begin
      state_n = IDLE;
      clr = 1'b1;
    end else if (bus.start) begin
      state_n = RUN;
      clr = 1'b1;
      load = 1'b1;
    end else begin
      case (state)
        IDLE: state_n = IDLE;
        RUN:
          if (bus.pause) state_n = HOLD;
          else if (term) begin
            done_n = 1'b1;
            tally = 1'b1;
            clr = mode_r;
            state_n = mode_r ? RUN : IDLE;
          end else en = 1'b1;
        HOLD: state_n = bus.pause ? HOLD : RUN;
        default: state_n = IDLE;
      endcase
    end
  end
  always_ff @(posedge ck or negedge res)
    if (!res) begin
      state <= IDLE;
      tc_r <= '0;
      mode_r <= 1'b0;
      done <= 1'b0;
      periods <= '0;
    end else begin
      state <= state_n;
      done <= done_n;
      if (load) begin
        tc_r <= bus.tc;
        mode_r <= bus.mode;
      end
      if (load) periods <= '0;
      else if (tally) periods <= periods + 1'b1;
    end
  assign bus.q = q;
  assign bus.done = done;
  assign bus.periods = periods;
  assign bus.busy = state == RUN || state == HOLD;
endmodule
